// File: rtl/vga_text_render_if.sv
// Read ports toward the character RAM and font ROM, plus the VGA pixel/sync outputs.
// The renderer uses the master modport; memories and display sinks use the slave modport.
interface vga_text_render_if;
  logic [11:0] vaddress;
  logic [15:0] vdata;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_de;
  logic        frame_start;

  modport master (
    output vaddress, font_addr, vga_r, vga_g, vga_b,
           vga_hsync, vga_vsync, vga_de, frame_start,
    input  vdata, font_data
  );

  modport slave (
    input  vaddress, font_addr, vga_r, vga_g, vga_b,
           vga_hsync, vga_vsync, vga_de, frame_start,
    output vdata, font_data
  );
endinterface

// File: rtl/vga_text_render.sv
// 640x480@60 text renderer: 80x30 cells of 8x16 px, char RAM -> font ROM -> RGB444 with 7-cycle latency.
// Define VGA_TEXT_ATTR_EN to colour each cell from vdata[15:8] (IRGB fg/bg indices).
module vga_text_render #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          COLS     = 80,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic               vclock,
  input  logic               vreset_n,
  vga_text_render_if.master  bus
);

  localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;

  always_ff @(posedge vclock or negedge vreset_n) begin
    if (!vreset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  logic        active0;
  logic        hsync0;
  logic        vsync0;
  logic        first0;
  logic [6:0]  col;
  logic [4:0]  row;
  logic [11:0] cell_addr;

  always_comb begin
    active0   = (hcnt < H_ACT) && (vcnt < V_ACT);
    hsync0    = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
    vsync0    = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
    first0    = (hcnt == '0) && (vcnt == '0);
    col       = hcnt[9:3];
    row       = vcnt[8:4];
    cell_addr = 12'(row * COLS) + {5'd0, col};
  end

  // Stage k of these shift registers holds the flags of the pixel whose counters were seen k cycles ago.
  logic [6:1]  valid_d;
  logic [6:1]  act_d;
  logic [6:1]  hs_d;
  logic [6:1]  vs_d;
  logic [6:1]  fs_d;
  logic [2:0]  px_d [1:6];
  logic [3:0]  gr_d [1:3];
  logic [11:0] vaddress_q;

  always_ff @(posedge vclock or negedge vreset_n) begin
    if (!vreset_n) begin
      valid_d    <= '0;
      act_d      <= '0;
      hs_d       <= '1;
      vs_d       <= '1;
      fs_d       <= '0;
      vaddress_q <= '0;
      for (int i = 1; i <= 6; i++) px_d[i] <= '0;
      for (int i = 1; i <= 3; i++) gr_d[i] <= '0;
    end else begin
      valid_d    <= {valid_d[5:1], 1'b1};
      act_d      <= {act_d[5:1], active0};
      hs_d       <= {hs_d[5:1], hsync0};
      vs_d       <= {vs_d[5:1], vsync0};
      fs_d       <= {fs_d[5:1], first0};
      vaddress_q <= active0 ? cell_addr : 12'd0;
      px_d[1]    <= hcnt[2:0];
      for (int i = 2; i <= 6; i++) px_d[i] <= px_d[i-1];
      gr_d[1]    <= vcnt[3:0];
      for (int i = 2; i <= 3; i++) gr_d[i] <= gr_d[i-1];
    end
  end

  logic        cell_load;
  logic [11:0] font_addr_q;

  assign cell_load = valid_d[3] && act_d[3];

  // The font address only moves for visible cells; during blanking it keeps the last glyph row.
  always_ff @(posedge vclock or negedge vreset_n) begin
    if (!vreset_n) begin
      font_addr_q <= '0;
    end else if (cell_load) begin
      font_addr_q <= {bus.vdata[7:0], gr_d[3]};
    end
  end

  logic [11:0] fg_rgb;
  logic [11:0] bg_rgb;

`ifdef VGA_TEXT_ATTR_EN
  logic [7:0] attr_d [4:6];
  localparam logic [23:0] unused_colors = {FG_COLOR, BG_COLOR};

  // bit3 = intensity, bits 2..0 = R,G,B; intensity alone gives dark grey instead of black.
  function automatic logic [11:0] irgb(input logic [3:0] idx);
    logic [3:0] lvl;
    lvl = idx[3] ? 4'hF : 4'hA;
    if (idx == 4'h8) return 12'h555;
    return {idx[2] ? lvl : 4'h0, idx[1] ? lvl : 4'h0, idx[0] ? lvl : 4'h0};
  endfunction

  always_ff @(posedge vclock or negedge vreset_n) begin
    if (!vreset_n) begin
      for (int i = 4; i <= 6; i++) attr_d[i] <= '0;
    end else begin
      if (cell_load) attr_d[4] <= bus.vdata[15:8];
      attr_d[5] <= attr_d[4];
      attr_d[6] <= attr_d[5];
    end
  end

  assign fg_rgb = irgb(attr_d[6][3:0]);
  assign bg_rgb = irgb(attr_d[6][7:4]);
`else
  logic unused_attr;

  assign unused_attr = &{1'b0, bus.vdata[15:8]};
  assign fg_rgb      = FG_COLOR;
  assign bg_rgb      = BG_COLOR;
`endif

  logic        pix_bit;
  logic [11:0] pix_rgb;

  always_comb begin
    pix_bit = bus.font_data[3'd7 - px_d[6]];
    pix_rgb = act_d[6] ? (pix_bit ? fg_rgb : bg_rgb) : 12'h000;
  end

  logic [11:0] rgb_q;
  logic        hsync_q;
  logic        vsync_q;
  logic        de_q;
  logic        frame_start_q;

  // Outputs keep their reset values until the first pixel has travelled the whole pipeline.
  always_ff @(posedge vclock or negedge vreset_n) begin
    if (!vreset_n) begin
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (valid_d[6]) begin
      rgb_q         <= pix_rgb;
      hsync_q       <= hs_d[6];
      vsync_q       <= vs_d[6];
      de_q          <= act_d[6];
      frame_start_q <= fs_d[6];
    end
  end

  assign bus.vaddress    = vaddress_q;
  assign bus.font_addr   = font_addr_q;
  assign bus.vga_r       = rgb_q[11:8];
  assign bus.vga_g       = rgb_q[7:4];
  assign bus.vga_b       = rgb_q[3:0];
  assign bus.vga_hsync   = hsync_q;
  assign bus.vga_vsync   = vsync_q;
  assign bus.vga_de      = de_q;
  assign bus.frame_start = frame_start_q;

endmodule
